alu_arbiter: RTL and testbench

Shares the single RV32I ALU between two requesters, for example the execute stage and an address/branch-target helper. Each requester presents an operation over a valid/ready handshake. The block arbitrates, registers the winning operands and drives the ALU from them for one cycle. It then returns the registered result and zero flag to the winning requester over a second valid/ready handshake, with at most one operation in flight.

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared RV32I ALU: arbitrate, register operands,
// run the ALU for one cycle, and return the registered result to the winner.
module alu_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_vld,
  output logic        req0_rdy,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_opc,
  input  logic        req1_vld,
  output logic        req1_rdy,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_opc,
  output logic        rsp0_vld,
  input  logic        rsp0_rdy,
  output logic [31:0] rsp0_rslt,
  output logic        rsp0_zr,
  output logic        rsp1_vld,
  input  logic        rsp1_rdy,
  output logic [31:0] rsp1_rslt,
  output logic        rsp1_zr,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_opc,
  input  logic [31:0] alu_rslt,
  input  logic        alu_zr,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where both vld and rdy
  // are high; vld must not drop, and its payload must not change, until then.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        owner;
  logic        last;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [2:0]  opc;
  logic [31:0] rslt;
  logic        zr;
  logic        gnt_vld;
  logic        gnt_id;
  logic        rsp_ack;

  // Grants are offered only in IDLE and never while reset is being applied.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state == IDLE && !rst) begin
      if (req0_vld && req1_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = (PRIO_FIXED != 0) ? 1'b0 : ~last;
      end else if (req0_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_vld) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign rsp_ack = owner ? rsp1_rdy : rsp0_rdy;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_vld) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (rsp_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      opa   <= 32'd0;
      opb   <= 32'd0;
      opc   <= 3'd0;
      rslt  <= 32'd0;
      zr    <= 1'b0;
    end else begin
      state <= state_nx;
      if (gnt_vld) begin
        opa   <= gnt_id ? req1_a : req0_a;
        opb   <= gnt_id ? req1_b : req0_b;
        opc   <= gnt_id ? req1_opc : req0_opc;
        owner <= gnt_id;
        last  <= gnt_id;
      end
      if (state == EXEC) begin
        rslt <= alu_rslt;
        zr   <= alu_zr;
      end
    end
  end

  assign req0_rdy  = gnt_vld && !gnt_id;
  assign req1_rdy  = gnt_vld && gnt_id;
  assign rsp0_vld  = (state == RESP) && !owner && !rst;
  assign rsp1_vld  = (state == RESP) && owner && !rst;
  assign rsp0_rslt = rslt;
  assign rsp1_rslt = rslt;
  assign rsp0_zr   = zr;
  assign rsp1_zr   = zr;
  assign alu_a     = opa;
  assign alu_b     = opb;
  assign alu_opc   = opc;
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin instance plus a fixed-priority instance, each
// wired to a behavioural ALU; a monitor checks grants and responses against queues.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index r = 2*instance + requester; instance 0 round-robin, instance 1 fixed priority
  logic        req_vld[4];
  logic        req_rdy[4];
  logic [31:0] req_a[4];
  logic [31:0] req_b[4];
  logic [2:0]  req_opc[4];
  logic        rsp_vld[4];
  logic        rsp_rdy[4];
  logic [31:0] rsp_rslt[4];
  logic        rsp_zr[4];

  logic [31:0] alu_a0, alu_b0, alu_r0, alu_a1, alu_b1, alu_r1;
  logic [2:0]  alu_op0, alu_op1;
  logic        alu_z0, alu_z1;
  logic [1:0]  dbg0, dbg1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_gnt[2];

  // {inst, port, zr, rslt}
  logic [34:0] exp_q[$];
  // {inst, requester, expected cycles since previous grant (0 = unchecked)}
  logic [9:0]  exp_g_q[$];

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
      OP_SLL:  return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  assign alu_r0 = alu_f(alu_a0, alu_b0, alu_op0);
  assign alu_z0 = (alu_r0 == 32'd0);
  assign alu_r1 = alu_f(alu_a1, alu_b1, alu_op1);
  assign alu_z1 = (alu_r1 == 32'd0);

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst),
    .req0_vld(req_vld[0]), .req0_rdy(req_rdy[0]), .req0_a(req_a[0]), .req0_b(req_b[0]), .req0_opc(req_opc[0]),
    .req1_vld(req_vld[1]), .req1_rdy(req_rdy[1]), .req1_a(req_a[1]), .req1_b(req_b[1]), .req1_opc(req_opc[1]),
    .rsp0_vld(rsp_vld[0]), .rsp0_rdy(rsp_rdy[0]), .rsp0_rslt(rsp_rslt[0]), .rsp0_zr(rsp_zr[0]),
    .rsp1_vld(rsp_vld[1]), .rsp1_rdy(rsp_rdy[1]), .rsp1_rslt(rsp_rslt[1]), .rsp1_zr(rsp_zr[1]),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_opc(alu_op0), .alu_rslt(alu_r0), .alu_zr(alu_z0),
    .dbg_state(dbg0)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fix (
    .clk(clk), .rst(rst),
    .req0_vld(req_vld[2]), .req0_rdy(req_rdy[2]), .req0_a(req_a[2]), .req0_b(req_b[2]), .req0_opc(req_opc[2]),
    .req1_vld(req_vld[3]), .req1_rdy(req_rdy[3]), .req1_a(req_a[3]), .req1_b(req_b[3]), .req1_opc(req_opc[3]),
    .rsp0_vld(rsp_vld[2]), .rsp0_rdy(rsp_rdy[2]), .rsp0_rslt(rsp_rslt[2]), .rsp0_zr(rsp_zr[2]),
    .rsp1_vld(rsp_vld[3]), .rsp1_rdy(rsp_rdy[3]), .rsp1_rslt(rsp_rslt[3]), .rsp1_zr(rsp_zr[3]),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_opc(alu_op1), .alu_rslt(alu_r1), .alu_zr(alu_z1),
    .dbg_state(dbg1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_rsp(input int inst, input int port, input logic zr, input logic [31:0] v);
    exp_q.push_back({inst[0], port[0], zr, v});
  endtask

  task automatic exp_gnt(input int inst, input int id, input int gap);
    exp_g_q.push_back({inst[0], id[0], gap[7:0]});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    req_opc[r] = op;
    req_a[r]   = a;
    req_b[r]   = b;
    req_vld[r] = 1'b1;
    @(negedge clk);
    while (!req_rdy[r] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy[r]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d got no grant in 100 cycles, expected one", r);
    end
    @(posedge clk);
    #1;
    req_vld[r] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_g_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || exp_g_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses and %0d grants still pending, expected 0", exp_q.size(), exp_g_q.size());
      exp_q.delete();
      exp_g_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- requester rule assertion ----------------
  logic        pend[4];
  logic [66:0] pend_v[4];
  always @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (pend[r])
        assert (req_vld[r] && {req_opc[r], req_a[r], req_b[r]} == pend_v[r])
          else $error("requester %0d withdrew or changed its request before grant", r);
      pend[r]   <= !rst && req_vld[r] && !req_rdy[r];
      pend_v[r] <= {req_opc[r], req_a[r], req_b[r]};
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic        prev_vld[4];
  logic [31:0] prev_rslt[4];
  logic        prev_zr[4];
  always @(negedge clk) begin : mon
    logic [34:0] e;
    logic [9:0]  g;
    int r;
    int o;
    if (rst) begin
      for (int k = 0; k < 4; k++) prev_vld[k] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_rdy[2*i] && req_rdy[2*i+1]) begin
          checks++;
          errors++;
          $display("FAIL double_grant: instance %0d granted both requesters, expected one", i);
        end
        for (int p = 0; p < 2; p++) begin
          r = 2*i + p;
          o = 2*i + (1 - p);
          if (req_rdy[r]) begin
            if (exp_g_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_grant: instance %0d requester %0d granted, expected no grant", i, p);
            end else begin
              g = exp_g_q.pop_front();
              chk("grant_id", 35'({i[0], p[0]}), 35'(g[9:8]));
              if (g[7:0] != 8'd0) chk("grant_gap", 35'(cyc - last_gnt[i]), 35'(g[7:0]));
            end
            last_gnt[i] = cyc;
          end
          if (rsp_vld[r]) begin
            chk("rsp_exclusive", 35'(rsp_vld[o]), 35'd0);
            if (!prev_vld[r]) chk("rsp_latency", 35'(cyc - last_gnt[i]), 35'd2);
            else chk("rsp_hold", {2'b00, rsp_zr[r], rsp_rslt[r]}, {2'b00, prev_zr[r], prev_rslt[r]});
            if (rsp_rdy[r]) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: instance %0d port %0d rslt %h, expected none", i, p, rsp_rslt[r]);
              end else begin
                e = exp_q.pop_front();
                chk("rsp_data", {i[0], p[0], rsp_zr[r], rsp_rslt[r]}, e);
              end
            end
          end
          prev_vld[r]  = rsp_vld[r] && !rsp_rdy[r];
          prev_rslt[r] = rsp_rslt[r];
          prev_zr[r]   = rsp_zr[r];
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    for (int k = 0; k < 4; k++) begin
      req_vld[k] = 1'b0;
      req_a[k]   = 32'd0;
      req_b[k]   = 32'd0;
      req_opc[k] = 3'd0;
      rsp_rdy[k] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state0", 35'(dbg0), 35'd0);
    chk("reset_state1", 35'(dbg1), 35'd0);
    chk("reset_alu_a", 35'(alu_a0), 35'd0);
    chk("reset_alu_b", 35'(alu_b0), 35'd0);
    chk("reset_alu_opc", 35'(alu_op0), 35'd0);
    chk("reset_rslt_zr", {2'b00, rsp_zr[0], rsp_rslt[0]}, 35'd0);
    chk("reset_rsp_vld", 35'({rsp_vld[0], rsp_vld[1], rsp_vld[2], rsp_vld[3]}), 35'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single requester 0, then single requester 1 back to back
    exp_gnt(0, 0, 0); exp_rsp(0, 0, 1'b0, 32'd12);
    drive(0, OP_ADD, 32'd5, 32'd7);
    wait_drain();
    exp_gnt(0, 1, 0); exp_rsp(0, 1, 1'b1, 32'd0);
    drive(1, OP_SUB, 32'h1234, 32'h1234);
    exp_gnt(0, 1, 3); exp_rsp(0, 1, 1'b0, 32'd1);
    drive(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    wait_drain();

    // both valid continuously, round-robin
    exp_gnt(0, 0, 0); exp_rsp(0, 0, 1'b0, 32'h0F0F_0F0F);
    exp_gnt(0, 1, 3); exp_rsp(0, 1, 1'b0, 32'h10);
    exp_gnt(0, 0, 3); exp_rsp(0, 0, 1'b0, 32'h0F0F_0F0F);
    exp_gnt(0, 1, 3); exp_rsp(0, 1, 1'b0, 32'h10);
    fork
      begin
        drive(0, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        drive(0, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
      end
      begin
        drive(1, OP_SLL, 32'd1, 32'd4);
        drive(1, OP_SLL, 32'd1, 32'd4);
      end
    join
    wait_drain();

    // response backpressure on requester 0 while requester 1 waits
    rsp_rdy[0] = 1'b0;
    exp_gnt(0, 0, 0); exp_rsp(0, 0, 1'b0, 32'h0F00_0F00);
    exp_gnt(0, 1, 7); exp_rsp(0, 1, 1'b0, 32'h8000_0000);
    fork
      drive(0, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
      drive(1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
      begin : bp
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_vld[0] && n < 50) begin
          @(negedge clk);
          n++;
        end
        repeat (4) @(posedge clk);
        #1;
        rsp_rdy[0] = 1'b1;
      end
    join
    wait_drain();

    // reset during EXEC, requests raised while reset is high
    exp_gnt(0, 0, 0);
    drive(0, OP_OR, 32'h0F, 32'hF0);
    rst = 1'b1;
    req_opc[0] = OP_SRL; req_a[0] = 32'h8000_0000; req_b[0] = 32'd31; req_vld[0] = 1'b1;
    req_opc[1] = OP_XOR; req_a[1] = 32'd5;         req_b[1] = 32'd5;  req_vld[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_state", 35'(dbg0), 35'd0);
    chk("rst_mid_rsp_vld", 35'({rsp_vld[0], rsp_vld[1]}), 35'd0);
    chk("rst_mid_alu", {alu_op0, alu_a0}, 35'd0);
    chk("rst_mid_alu_b", 35'(alu_b0), 35'd0);
    chk("rst_mid_rslt", {2'b00, rsp_zr[0], rsp_rslt[0]}, 35'd0);
    chk("rst_req_rdy", 35'({req_rdy[0], req_rdy[1]}), 35'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_gnt(0, 0, 0); exp_rsp(0, 0, 1'b0, 32'd1);
    exp_gnt(0, 1, 3); exp_rsp(0, 1, 1'b1, 32'd0);
    fork
      drive(0, OP_SRL, 32'h8000_0000, 32'd31);
      drive(1, OP_XOR, 32'd5, 32'd5);
    join
    wait_drain();

    // fixed-priority instance: requester 0 keeps winning while both are valid
    exp_gnt(1, 0, 0); exp_rsp(1, 0, 1'b0, 32'h0F0F_0F0F);
    exp_gnt(1, 0, 3); exp_rsp(1, 0, 1'b0, 32'h0F0F_0F0F);
    exp_gnt(1, 0, 3); exp_rsp(1, 0, 1'b0, 32'h0F0F_0F0F);
    exp_gnt(1, 1, 3); exp_rsp(1, 1, 1'b0, 32'h10);
    fork
      begin
        drive(2, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        drive(2, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
        drive(2, OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
      end
      drive(3, OP_SLL, 32'd1, 32'd4);
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
